// File: rtl/accum_buf.sv
// Accumulation buffer: BATCH-lane accumulator RAM fed by the conv address
// generator through a 3-stage read-modify-write pipeline with hazard
// forwarding, plus a drain port with optional clear-on-read.

package global_param;
  localparam int BATCH = 4;
endpackage

module accum_buf #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int ACC_W  = 32,
  parameter int BATCH  = global_param::BATCH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_W-1:0]       acc_addr,
  input  logic [BATCH-1:0]        acc_en,
  input  logic                    acc_new,
  input  logic [BATCH*DATA_W-1:0] acc_data,
  input  logic                    rd_req,
  input  logic [ADDR_W-1:0]       rd_addr,
  input  logic                    rd_clr,
  output logic                    rd_ready,
  output logic                    rd_valid,
  output logic [BATCH*ACC_W-1:0]  rd_data,
  output logic                    busy
);

  localparam int WORD_W = BATCH * ACC_W;
  localparam int DEPTH  = 1 << ADDR_W;

  // Next value of one accumulator lane: hold, overwrite, or saturating add.
  function automatic logic [ACC_W-1:0] lane_next(input logic [ACC_W-1:0]  stored,
                                                 input logic [DATA_W-1:0] d,
                                                 input logic              en,
                                                 input logic              nw);
    logic [ACC_W-1:0] ext;
    logic [ACC_W:0]   s;
    ext = {{(ACC_W-DATA_W){d[DATA_W-1]}}, d};
    s   = {stored[ACC_W-1], stored} + {ext[ACC_W-1], ext};
    if (!en)                       return stored;
    if (nw)                        return ext;
    if (s[ACC_W] != s[ACC_W-1])    return s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                                   : {1'b0, {(ACC_W-1){1'b1}}};
    return s[ACC_W-1:0];
  endfunction

  logic [WORD_W-1:0] mem [DEPTH];
  logic [WORD_W-1:0] ram_q;

  logic                    acc_req;
  logic                    rd_fire;
  logic [ADDR_W-1:0]       raddr;

  logic                    s1_valid;
  logic [ADDR_W-1:0]       s1_addr;
  logic [BATCH-1:0]        s1_en;
  logic                    s1_new;
  logic [BATCH*DATA_W-1:0] s1_data;
  logic [WORD_W-1:0]       s1_op;
  logic [WORD_W-1:0]       s1_sum;

  logic                    s2_valid;
  logic [ADDR_W-1:0]       s2_addr;
  logic [WORD_W-1:0]       s2_sum;

  logic                    clr_pend;
  logic [ADDR_W-1:0]       clr_addr;

  logic                    wr_en;
  logic [ADDR_W-1:0]       wr_addr;
  logic [WORD_W-1:0]       wr_data;

  // Copy of the write committed at the previous edge (distance-2 bypass).
  logic                    wb_valid;
  logic [ADDR_W-1:0]       wb_addr;
  logic [WORD_W-1:0]       wb_data;

  assign acc_req  = |acc_en;
  assign busy     = s1_valid | s2_valid;
  assign rd_ready = ~acc_req & ~busy;
  assign rd_fire  = rd_req & rd_ready;
  // The single read port serves the accumulator when it asks, else the drain.
  assign raddr    = acc_req ? acc_addr : rd_addr;

  // Write port arbitration: pipeline write-back or drain clear (never both).
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    wr_en   = 1'b0;
    wr_addr = s2_addr;
    wr_data = s2_sum;
    if (s2_valid) begin
      wr_en = 1'b1;
    end else if (clr_pend) begin
      wr_en   = 1'b1;
      wr_addr = clr_addr;
      wr_data = '0;
    end
    if (rst) wr_en = 1'b0;
  end

  // Accumulator RAM: synchronous write, 1-cycle registered read, old data on collision.
  always_ff @(posedge clk) begin
    // NOTE: the RAM array has no reset; only control state is cleared, committed words survive rst.
    if (wr_en) mem[wr_addr] <= wr_data;
    ram_q <= mem[raddr];
  end

  // S0 -> S1 request register.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for all registered state so every stage samples pre-edge values.
    if (rst) s1_valid <= 1'b0;
    else     s1_valid <= acc_req;
    s1_addr <= acc_addr;
    s1_en   <= acc_en;
    s1_new  <= acc_new;
    s1_data <= acc_data;
  end

  // S1 operand forwarding (youngest source wins) and per-lane update.
  always_comb begin
    if (s2_valid && s2_addr == s1_addr)      s1_op = s2_sum;
    else if (wb_valid && wb_addr == s1_addr) s1_op = wb_data;
    else                                     s1_op = ram_q;
    s1_sum = '0;
    for (int i = 0; i < BATCH; i++) begin
      s1_sum[i*ACC_W +: ACC_W] = lane_next(s1_op[i*ACC_W +: ACC_W],
                                           s1_data[i*DATA_W +: DATA_W],
                                           s1_en[i], s1_new);
    end
  end

  // S1 -> S2 register and record of the write committed at this edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      wb_valid <= 1'b0;
    end else begin
      s2_valid <= s1_valid;
      wb_valid <= wr_en;
    end
    s2_addr <= s1_addr;
    s2_sum  <= s1_sum;
    wb_addr <= wr_addr;
    wb_data <= wr_data;
  end

  // Drain port: same read port as the pipeline, bypassing a same-edge write.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
      clr_pend <= 1'b0;
    end else begin
      rd_valid <= rd_fire;
      clr_pend <= rd_fire & rd_clr;
      if (rd_fire) rd_data <= (wr_en && wr_addr == raddr) ? wr_data : mem[raddr];
    end
    clr_addr <= rd_addr;
  end

endmodule

// File: tb/tb_accum_buf.sv
// Directed scoreboard bench for accum_buf (BATCH=4, DATA_W=16, ACC_W=32).

module tb_accum_buf;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   acc_addr;
  logic [3:0]   acc_en;
  logic         acc_new;
  logic [63:0]  acc_data;
  logic         rd_req;
  logic [7:0]   rd_addr;
  logic         rd_clr;
  logic         rd_ready;
  logic         rd_valid;
  logic [127:0] rd_data;
  logic         busy;

  int total = 0;
  int bad   = 0;
  logic [127:0] exp_q [$];

  accum_buf dut (
    .clk(clk), .rst(rst),
    .acc_addr(acc_addr), .acc_en(acc_en), .acc_new(acc_new), .acc_data(acc_data),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_clr(rd_clr),
    .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rep32(input logic [31:0] v);
    return {4{v}};
  endfunction

  function automatic logic [63:0] rep16(input logic [15:0] v);
    return {4{v}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic acc(input logic [7:0] a, input logic [3:0] en, input logic nw,
                     input logic [63:0] d);
    acc_addr = a;
    acc_en   = en;
    acc_new  = nw;
    acc_data = d;
    tick();
    acc_en   = '0;
  endtask

  // Waits (bounded) for rd_ready, issues one drain and checks rd_valid at T+1.
  task automatic drain(input logic [7:0] a, input logic clr, input logic [127:0] exp);
    int n;
    acc_en  = '0;
    rd_req  = 1'b1;
    rd_addr = a;
    rd_clr  = clr;
    #1;
    n = 0;
    while (!rd_ready && n < 20) begin
      tick();
      n++;
    end
    check("rd_ready before drain", rd_ready, 1'b1);
    exp_q.push_back(exp);
    tick();
    rd_req = 1'b0;
    rd_clr = 1'b0;
    check("rd_valid at T+1", rd_valid, 1'b1);
  endtask

  // Scoreboard: every rd_valid pulse consumes one expected word.
  always @(negedge clk) begin
    if (!rst && rd_valid) begin
      if (exp_q.size() == 0) check("spurious rd_valid", rd_valid, 1'b0);
      else                   check("rd_data", rd_data, exp_q.pop_front());
    end
  end

  initial begin
    rst = 1'b1; acc_addr = '0; acc_en = '0; acc_new = 1'b0; acc_data = '0;
    rd_req = 1'b0; rd_addr = '0; rd_clr = 1'b0;
    tick();
    tick();
    check("reset busy", busy, 1'b0);
    check("reset rd_valid", rd_valid, 1'b0);
    check("reset rd_data", rd_data, '0);
    rst = 1'b0;
    #1;
    check("idle rd_ready", rd_ready, 1'b1);

    // Overwrite then drain.
    acc(8'd5, 4'hF, 1'b1, rep16(16'd3));
    check("busy after request", busy, 1'b1);
    tick();
    drain(8'd5, 1'b0, rep32(32'd3));
    tick();
    tick();
    check("rd_valid single pulse", rd_valid, 1'b0);
    check("rd_data holds", rd_data, rep32(32'd3));
    check("busy drained", busy, 1'b0);

    // Back-to-back adds: distance-1 and distance-2 forwarding.
    acc(8'd7, 4'hF, 1'b1, rep16(16'd1));
    for (int i = 0; i < 4; i++) acc(8'd7, 4'hF, 1'b0, rep16(16'd2));
    drain(8'd7, 1'b0, rep32(32'd9));

    // Lane mask.
    acc(8'd2, 4'hF, 1'b1, rep16(16'd10));
    acc(8'd2, 4'h1, 1'b0, rep16(16'd5));
    drain(8'd2, 1'b0, {32'd10, 32'd10, 32'd10, 32'd15});

    // Saturation: lanes 0,1 climb by +0x7FFF, lanes 2,3 fall by -0x8000.
    acc(8'd9, 4'hF, 1'b1, {16'h8000, 16'h8000, 16'h7FFF, 16'h7FFF});
    for (int i = 0; i < 65537; i++)
      acc(8'd9, 4'hF, 1'b0, {16'h8000, 16'h8000, 16'h7FFF, 16'h7FFF});
    drain(8'd9, 1'b0, {32'h8000_0000, 32'h8000_0000, 32'h7FFF_FFFE, 32'h7FFF_FFFE});
    acc(8'd9, 4'hF, 1'b0, {16'h8000, 16'h8000, 16'h7FFF, 16'h7FFF});
    drain(8'd9, 1'b0, {32'h8000_0000, 32'h8000_0000, 32'h7FFF_FFFF, 32'h7FFF_FFFF});

    // Clear-on-read followed immediately by an accumulate to the same word.
    acc(8'd3, 4'hF, 1'b1, rep16(16'd42));
    drain(8'd3, 1'b1, rep32(32'd42));
    acc(8'd3, 4'hF, 1'b0, rep16(16'd4));
    drain(8'd3, 1'b0, rep32(32'd4));

    // Drain request colliding with an accumulate is refused.
    acc_addr = 8'd11; acc_en = 4'hF; acc_new = 1'b1; acc_data = rep16(16'd6);
    rd_req = 1'b1; rd_addr = 8'd11;
    #1;
    check("rd_ready with acc_en", rd_ready, 1'b0);
    tick();
    acc_en = '0;
    rd_req = 1'b0;
    check("no rd_valid when refused", rd_valid, 1'b0);
    drain(8'd11, 1'b0, rep32(32'd6));

    // Reset while S1 and S2 hold requests.
    acc(8'd20, 4'hF, 1'b1, rep16(16'd8));
    acc(8'd20, 4'hF, 1'b0, rep16(16'd100));
    acc(8'd20, 4'hF, 1'b0, rep16(16'd100));
    check("busy before reset", busy, 1'b1);
    rst = 1'b1;
    tick();
    check("busy after mid reset", busy, 1'b0);
    check("rd_valid after mid reset", rd_valid, 1'b0);
    rst = 1'b0;
    drain(8'd20, 1'b0, rep32(32'd8));

    tick();
    tick();
    check("scoreboard empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/accum_buf.md
Name: accum_buf

Overview:
- Accumulation buffer directly downstream of the conv address generator, which supplies abuf_addr, abuf_acc_en and abuf_acc_new.
- Adds the per-batch-lane MAC results into a BATCH-lane-wide accumulator RAM using a pipelined read-modify-write with hazard forwarding.
- A drain port lets the output writer read finished sums, with optional clear-on-read.

Parameters:
- ADDR_W, 8, accumulator address width; depth is 2^ADDR_W words.
- DATA_W, 16, signed width of one MAC result lane.
- ACC_W, 32, signed width of one accumulator lane.
- Lane count is BATCH from GLOBAL_PARAM.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- acc_addr  in  ADDR_W  accumulate address; driven by abuf_addr
- acc_en  in  BATCH  per-lane enable; driven by abuf_acc_en; any bit set means a valid request
- acc_new  in  1  overwrite instead of add; driven by abuf_acc_new
- acc_data  in  BATCH*DATA_W  MAC results; lane i is bits [i*DATA_W +: DATA_W]
- rd_req  in  1  drain read request
- rd_addr  in  ADDR_W  drain address
- rd_clr  in  1  zero the word after it is read
- rd_ready  out  1  rd_req accepted this cycle
- rd_valid  out  1  rd_data valid
- rd_data  out  BATCH*ACC_W  drained word
- busy  out  1  an accumulate request is in flight

Behaviour:
- Reset:
  - All pipeline valids clear; rd_valid=0, rd_data=0, busy=0.
  - RAM contents are not reset. rst in mid-operation drops all in-flight requests; words already committed stay.
- RAM: single port-pair. 1-cycle synchronous read. Read-during-write to the same address returns OLD data.
- Accumulate pipeline, for a request presented at cycle T (any acc_en bit set):
  - S0 (T): RAM read issued at acc_addr; addr, en, new and data registered into S1.
  - S1 (T+1): RAM data available; operand selected through forwarding; sum computed into the S2 register.
  - S2 (T+2): write at the T+2 clock edge; the value is readable by requests issued at T+3 or later.
- Per-lane arithmetic:
  - DATA_W input is sign-extended to ACC_W.
  - new = stored + ext(data), saturated to the signed ACC_W range (max 2^(ACC_W-1)-1, min -2^(ACC_W-1)).
  - If acc_new=1: new = ext(data), no saturation needed.
  - If the lane's en bit is 0: the lane is written back unchanged.
- Forwarding in S1, applied per word, with the youngest source winning:
  - (a) S2 holds the same address → use S2's sum (distance-1 hazard).
  - (b) Else, the write committed in the previous cycle has the same address → use that written value (distance-2 hazard, covers RAM old-data behaviour).
  - (c) Else → use RAM data.
  - Consecutive and distance-2 requests to one address therefore accumulate exactly as if serialized.
- Drain port:
  - rd_ready = ~(|acc_en) & ~busy. Accumulate always has priority; rd_req with rd_ready=0 is ignored and the requester holds it.
  - Accepted read at T: rd_valid=1 and rd_data valid at T+1 for exactly one cycle; rd_data holds its value otherwise.
  - If rd_clr=1: the word is written to 0 at T+1.
  - A new accumulate at T+1 to the same address must see 0; forwarding rule (b) covers this.
- busy = S1 valid | S2 valid; it is 0 one cycle after the last write commits.
- acc_en=0 cycles insert bubbles; no stall or backpressure on the accumulate side; throughput is 1 request per cycle.

Test Plan:
- Overwrite then drain: acc_new=1, addr 5, all lanes data=3, then an idle cycle, then drain addr 5 → rd_data all lanes = 3, rd_valid high for 1 cycle at T+1.
- Back-to-back add: acc_new=1 data=1 at addr 7, then 4 consecutive cycles addr 7 data=2, acc_new=0 → drain gives 9 on every lane. Exercises distance-1 and distance-2 forwarding.
- Lane mask: addr 2 preloaded with 10, then acc_en=0x1, data=5 → lane0=15, all other lanes 10.
- Saturation: ACC_W=32, lane preloaded with 0x7FFFFFF0, add DATA_W value 0x7FFF → lane = 0x7FFFFFFF. Negative case with a -0x8000 step saturates at 0x80000000.
- Clear-on-read: drain addr 3 with rd_clr=1 (value 42), then next cycle accumulate addr 3 data=4 acc_new=0 → later drain gives 4. rd_req asserted alongside acc_en → rd_ready=0 and no rd_valid.
- Reset mid-stream: rst asserted while S1/S2 are valid → busy=0 and rd_valid=0 next cycle, and the dropped request has no effect on the RAM.
